floating_divide_seq: RTL and testbench
======================================

Name: floating_divide_seq

Overview:
Parametrised, multi-cycle IEEE-754-style floating-point divider. It is the successor to the single-cycle combinational-divide float unit.
- Operand and result widths are set by EXP_W and MAN_W.
- The mantissa quotient is computed with a radix-2 restoring iteration, so no wide "/" operator is needed.
- Adds a start/busy/done handshake, round-to-nearest-even, special-value handling and exception flags.
- Sits beside the other Phaethon float units, driven by the execute stage, which stalls on busy.

Parameters:
EXP_W, 8, exponent field width; bias is 2^(EXP_W-1)-1.
MAN_W, 23, stored fraction width; total word width W = 1+EXP_W+MAN_W.

Ports:
clk  in  1  rising-edge clock.
rst_n  in  1  reset; asynchronous, active-low.
start  in  1  request; sampled only in IDLE.
a  in  W  dividend (sign|exp|frac).
b  in  W  divisor.
busy  out  1  high from the cycle after accept until done.
done  out  1  one-cycle pulse; out and flags are valid in that cycle.
out  out  W  quotient; held until the next done.
flags  out  4  {invalid, div_by_zero, overflow, underflow}; held with out.

Behaviour:
- Reset (async assert, sync release): state=IDLE; busy=0, done=0, out=0, flags=0; all internal registers cleared.
- Reset mid-operation: the in-flight op is discarded and no done is produced.
- States: IDLE -> UNPACK -> DIVIDE -> ROUND -> DONE -> IDLE. UNPACK goes straight to DONE for special cases.
- Accept: in IDLE with start=1 at edge T, a and b are latched and busy=1 from T+1.
- start while busy, or in DONE: ignored, no queueing.
- Back-to-back ops: a new start is accepted in the cycle after done, once back in IDLE.
- UNPACK (T+1):
  - Denormal inputs are flushed to zero.
  - Implicit 1 is restored, giving (MAN_W+1)-bit significands.
  - sign = a.s ^ b.s.
  - exp = ea - eb + bias, computed in an (EXP_W+2)-bit signed register.
- Special-case priority, all resolved in UNPACK, with done at T+2:
  1. NaN operand, 0/0 or inf/inf -> canonical qNaN (exp all-ones, frac MSB=1, sign 0); invalid=1.
  2. x/0 with x finite nonzero -> signed inf; div_by_zero=1.
  3. inf/finite -> signed inf, no flag.
  4. 0/nonzero or finite/inf -> signed zero, no flag.
- DIVIDE: MAN_W+3 iterations, one quotient bit per cycle, cycles T+2..T+MAN_W+4.
  - Partial remainder is MAN_W+3 bits.
  - Each cycle: if rem >= divisor, then rem -= divisor and the quotient bit is 1.
  - sticky = (final rem != 0).
- ROUND (T+MAN_W+5):
  - Quotient in [0.5,2): if MSB=0, shift left 1 and decrement exp.
  - Round to nearest even using guard and sticky.
  - Mantissa carry-out renormalises and increments exp.
  - exp >= 2^EXP_W-1 -> signed inf; overflow=1.
  - exp <= 0 -> signed zero (flush to zero); underflow=1.
- DONE (T+MAN_W+6): done=1 and out/flags updated; next state IDLE with busy=0.
- Latency: normal = MAN_W+6 cycles from accept edge to done (29 by default); special = 2.
- Sign is preserved on zero/inf results; qNaN sign is always 0.

Decomposition:
- Package floating_divide_pkg holds:
  - state enum (IDLE, UNPACK, DIVIDE, ROUND, DONE)
  - flag bit indices
  - functions for bias, qNaN and inf constants, parametrised by EXP_W/MAN_W
- Sub-module mantissa_divider_iter: parametrised restoring divider.
  - Interface: load, step, divisor/dividend in; quotient, sticky, last out.
  - Owns the iteration counter.
  - The top level keeps the FSM, unpack, round and pack logic.

Test Plan:
- 6.0/2.0 (0x40C00000/0x40000000), start at T -> done at T+29, out=0x40400000, flags=0; busy high T+1..T+28.
- 1.0/3.0 (0x3F800000/0x40400000) -> out=0x3EAAAAAB, proving the RNE round-up; -1.0/3.0 -> 0xBEAAAAAB.
- 1.0/0.0 -> done at T+2, out=0x7F800000, div_by_zero=1.
- 0.0/0.0 -> out=0x7FC00000, invalid=1.
- inf/2.0 (0x7F800000/0x40000000) -> out=0x7F800000, no flag.
- 0x7F000000/0x3E800000 -> out=0x7F800000, overflow=1.
- 0x00800000/0x40800000 -> out=0x00000000, underflow=1.
- start pulsed at T+5 during busy -> ignored, single done.
- Back-to-back: second start at the done+1 edge is accepted.
- rst_n low at T+10 -> outputs 0 immediately, no done follows.
- Param sweep EXP_W=5, MAN_W=10: 0x4600/0x4000 (6/2) -> out=0x4200, done at T+16.

Source files
------------

// File: rtl/floating_divide_pkg.sv
// Shared types and constant builders for the sequential floating-point divider.
// Word constants are built at 64 bits; callers slice them to their own word width.
package floating_divide_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_UNPACK,
        ST_DIVIDE,
        ST_ROUND,
        ST_DONE
    } state_t;

    localparam int unsigned FLAG_INVALID   = 3;
    localparam int unsigned FLAG_DIV_ZERO  = 2;
    localparam int unsigned FLAG_OVERFLOW  = 1;
    localparam int unsigned FLAG_UNDERFLOW = 0;

    localparam int unsigned WORD_MAX = 64;

    function automatic int unsigned exp_bias(input int unsigned exp_w);
        return (32'd1 << (exp_w - 1)) - 32'd1;
    endfunction

    // Positive infinity: exponent all ones, fraction zero.
    function automatic logic [WORD_MAX-1:0] inf_word(input int unsigned exp_w,
                                                     input int unsigned man_w);
        return ((64'd1 << exp_w) - 64'd1) << man_w;
    endfunction

    // Canonical quiet NaN: positive, exponent all ones, fraction MSB set.
    function automatic logic [WORD_MAX-1:0] qnan_word(input int unsigned exp_w,
                                                      input int unsigned man_w);
        return inf_word(exp_w, man_w) | (64'd1 << (man_w - 1));
    endfunction

endpackage

// File: rtl/floating_divide_seq_iter.sv
// Radix-2 restoring significand divider: one quotient bit per step, exact sticky
// from the final partial remainder.
module mantissa_divider_iter
    import floating_divide_pkg::*;
#(
    parameter int unsigned SIG_W = 24,
    parameter int unsigned QUO_W = 26
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic [SIG_W-1:0] divisor,
    input  logic [SIG_W-1:0] dividend,
    output logic [QUO_W-1:0] quotient,
    output logic             sticky,
    output logic             last
);

    localparam int unsigned CW = $clog2(QUO_W);

    logic [QUO_W-1:0] rem;
    logic [QUO_W-1:0] rem_sub;
    logic [QUO_W-1:0] div_ext;
    logic [SIG_W-1:0] div_r;
    logic [CW-1:0]    cnt;
    logic             ge;

    always_comb begin
        div_ext = {{(QUO_W-SIG_W){1'b0}}, div_r};
        ge      = (rem >= div_ext);
        rem_sub = ge ? (rem - div_ext) : rem;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem      <= '0;
            div_r    <= '0;
            quotient <= '0;
            cnt      <= '0;
        end else if (load) begin
            rem      <= {{(QUO_W-SIG_W){1'b0}}, dividend};
            div_r    <= divisor;
            quotient <= '0;
            cnt      <= '0;
        end else if (step) begin
            rem      <= rem_sub << 1;
            quotient <= {quotient[QUO_W-2:0], ge};
            cnt      <= cnt + CW'(1);
        end
    end

    assign sticky = |rem;
    assign last   = step && (cnt == CW'(QUO_W - 1));

endmodule

// File: rtl/floating_divide_seq.sv
// Multi-cycle floating-point divider: start/busy/done handshake, flush-to-zero
// denormals, round-to-nearest-even and {invalid, div_by_zero, overflow, underflow} flags.
module floating_divide_seq
    import floating_divide_pkg::*;
#(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    output logic                   busy,
    output logic                   done,
    output logic [EXP_W+MAN_W:0]   out,
    output logic [3:0]             flags
);

    localparam int unsigned W  = 1 + EXP_W + MAN_W;
    localparam int unsigned SW = MAN_W + 1;
    localparam int unsigned QW = MAN_W + 3;
    localparam int unsigned XW = EXP_W + 2;

    localparam logic [WORD_MAX-1:0] INF_FULL  = inf_word(EXP_W, MAN_W);
    localparam logic [WORD_MAX-1:0] QNAN_FULL = qnan_word(EXP_W, MAN_W);
    localparam logic [W-1:0]        INF_POS   = INF_FULL[W-1:0];
    localparam logic [W-1:0]        QNAN      = QNAN_FULL[W-1:0];
    localparam logic [XW-1:0]       BIAS      = XW'(exp_bias(EXP_W));
    localparam logic [XW-1:0]       EXP_MAX   = XW'((1 << EXP_W) - 1);

    state_t state, state_n;

    logic [W-1:0]  a_r, b_r, res_r;
    logic [3:0]    rflags_r;
    logic          sign_r;
    logic [XW-1:0] exp_r;

    logic               a_sign, b_sign;
    logic [EXP_W-1:0]   ea, eb;
    logic [MAN_W-1:0]   fa, fb;
    logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [SW-1:0]      ma, mb;
    logic [XW-1:0]      exp_unpack;
    logic               sign_q;
    logic               spec_hit;
    logic [W-1:0]       spec_word;
    logic [3:0]         spec_flags;

    logic [QW-1:0]  quotient;
    logic           div_sticky, div_last;

    logic           q_msb, guard, sticky_r, round_up;
    logic [SW-1:0]  mant_pre;
    logic [SW:0]    mant_sum;
    logic [XW-1:0]  exp_pre, exp_rnd;
    logic [MAN_W-1:0] frac_rnd;
    logic [W-1:0]   round_word;
    logic [3:0]     round_flags;

    // Denormals have a zero exponent field and are treated as zero.
    always_comb begin
        {a_sign, ea, fa} = a_r;
        {b_sign, eb, fb} = b_r;
        a_nan  = (&ea) && (|fa);
        b_nan  = (&eb) && (|fb);
        a_inf  = (&ea) && !(|fa);
        b_inf  = (&eb) && !(|fb);
        a_zero = !(|ea);
        b_zero = !(|eb);
        ma     = {1'b1, fa};
        mb     = {1'b1, fb};
        sign_q = a_sign ^ b_sign;
        exp_unpack = {2'b00, ea} - {2'b00, eb} + BIAS;
    end

    always_comb begin
        spec_hit   = 1'b1;
        spec_word  = '0;
        spec_flags = '0;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_word                 = QNAN;
            spec_flags[FLAG_INVALID]  = 1'b1;
        end else if (b_zero && !a_inf) begin
            spec_word                 = {sign_q, INF_POS[W-2:0]};
            spec_flags[FLAG_DIV_ZERO] = 1'b1;
        end else if (a_inf) begin
            spec_word = {sign_q, INF_POS[W-2:0]};
        end else if (a_zero || b_inf) begin
            spec_word = {sign_q, {(W-1){1'b0}}};
        end else begin
            spec_hit = 1'b0;
        end
    end

    mantissa_divider_iter #(
        .SIG_W(SW),
        .QUO_W(QW)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     ((state == ST_UNPACK) && !spec_hit),
        .step     (state == ST_DIVIDE),
        .divisor  (mb),
        .dividend (ma),
        .quotient (quotient),
        .sticky   (div_sticky),
        .last     (div_last)
    );

    // Quotient lies in (0.5, 2); a clear MSB means one extra normalising shift.
    always_comb begin
        q_msb    = quotient[QW-1];
        mant_pre = q_msb ? quotient[QW-1:2] : quotient[QW-2:1];
        guard    = q_msb ? quotient[1] : quotient[0];
        sticky_r = q_msb ? (quotient[0] | div_sticky) : div_sticky;
        exp_pre  = q_msb ? exp_r : (exp_r - XW'(1));
        round_up = guard & (sticky_r | mant_pre[0]);
        mant_sum = {1'b0, mant_pre} + (SW+1)'(round_up);
        exp_rnd  = exp_pre + XW'(mant_sum[SW]);
        frac_rnd = MAN_W'(mant_sum >> mant_sum[SW]);
        round_flags = '0;
        if (!exp_rnd[XW-1] && (exp_rnd >= EXP_MAX)) begin
            round_word                  = {sign_r, INF_POS[W-2:0]};
            round_flags[FLAG_OVERFLOW]  = 1'b1;
        end else if (exp_rnd[XW-1] || (exp_rnd == '0)) begin
            round_word                  = {sign_r, {(W-1){1'b0}}};
            round_flags[FLAG_UNDERFLOW] = 1'b1;
        end else begin
            round_word = {sign_r, exp_rnd[EXP_W-1:0], frac_rnd};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:   if (start) state_n = ST_UNPACK;
            ST_UNPACK: state_n = spec_hit ? ST_DONE : ST_DIVIDE;
            ST_DIVIDE: if (div_last) state_n = ST_ROUND;
            ST_ROUND:  state_n = ST_DONE;
            ST_DONE:   state_n = ST_IDLE;
            default:   state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r      <= '0;
            b_r      <= '0;
            sign_r   <= 1'b0;
            exp_r    <= '0;
            res_r    <= '0;
            rflags_r <= '0;
            done     <= 1'b0;
            out      <= '0;
            flags    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: if (start) begin
                    a_r <= a;
                    b_r <= b;
                end
                ST_UNPACK: begin
                    sign_r <= sign_q;
                    exp_r  <= exp_unpack;
                    if (spec_hit) begin
                        res_r    <= spec_word;
                        rflags_r <= spec_flags;
                    end
                end
                ST_ROUND: begin
                    res_r    <= round_word;
                    rflags_r <= round_flags;
                end
                ST_DONE: begin
                    done  <= 1'b1;
                    out   <= res_r;
                    flags <= rflags_r;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == ST_DIVIDE) || (state == ST_ROUND) || (state == ST_DONE);

endmodule

// File: tb/tb_floating_divide_seq.sv
// Scoreboard bench for floating_divide_seq at single (8/23) and half (5/10) formats.
module tb_floating_divide_seq;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        start0 = 1'b0;
    logic [31:0] a0 = '0, b0 = '0;
    logic        busy0, done0;
    logic [31:0] out0;
    logic [3:0]  flags0;
    logic        start1 = 1'b0;
    logic [15:0] a1 = '0, b1 = '0;
    logic        busy1, done1;
    logic [15:0] out1;
    logic [3:0]  flags1;

    int          checks   = 0;
    int          failures = 0;
    int unsigned cyc      = 0;
    int unsigned blo [2]  = '{1, 1};
    int unsigned bhi [2]  = '{0, 0};

    typedef struct {
        logic [63:0] res;
        logic [3:0]  fl;
        int unsigned due;
    } exp_t;

    exp_t sb0 [$];
    exp_t sb1 [$];

    floating_divide_seq #(.EXP_W(8), .MAN_W(23)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .a(a0), .b(b0),
        .busy(busy0), .done(done0), .out(out0), .flags(flags0)
    );

    floating_divide_seq #(.EXP_W(5), .MAN_W(10)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .out(out1), .flags(flags1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: exact quotient scaled by 2^40, rounded to nearest even on the exact remainder.
    function automatic void ref_div(input int unsigned ew, input int unsigned mw,
                                    input logic [63:0] av, input logic [63:0] bv,
                                    output logic [63:0] res, output logic [3:0] fl,
                                    output int unsigned lat);
        logic [63:0] emax, fmask, ea, eb, fa, fb, sgn, inf, ma, mb, num, q, rm, mant, rbits, half;
        bit a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        int e;
        int unsigned sh;
        emax  = (64'd1 << ew) - 64'd1;
        fmask = (64'd1 << mw) - 64'd1;
        ea = (av >> mw) & emax;  fa = av & fmask;
        eb = (bv >> mw) & emax;  fb = bv & fmask;
        sgn = ((av >> (ew + mw)) ^ (bv >> (ew + mw))) & 64'd1;
        inf = (sgn << (ew + mw)) | (emax << mw);
        a_nan = (ea == emax) && (fa != 0);  b_nan = (eb == emax) && (fb != 0);
        a_inf = (ea == emax) && (fa == 0);  b_inf = (eb == emax) && (fb == 0);
        a_zero = (ea == 0);                 b_zero = (eb == 0);
        fl = 4'b0000;
        lat = 2;
        res = 64'd0;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            res = (emax << mw) | (64'd1 << (mw - 1));
            fl  = 4'b1000;
        end else if (b_zero && !a_inf) begin
            res = inf;
            fl  = 4'b0100;
        end else if (a_inf) begin
            res = inf;
        end else if (a_zero || b_inf) begin
            res = sgn << (ew + mw);
        end else begin
            lat = mw + 6;
            ma  = fa | (64'd1 << mw);
            mb  = fb | (64'd1 << mw);
            num = ma << 40;
            q   = num / mb;
            rm  = num % mb;
            e   = int'(ea) - int'(eb) + ((1 << (ew - 1)) - 1);
            if (q < (64'd1 << 40)) begin
                e  = e - 1;
                sh = 39 - mw;
            end else begin
                sh = 40 - mw;
            end
            mant  = q >> sh;
            rbits = q & ((64'd1 << sh) - 64'd1);
            half  = 64'd1 << (sh - 1);
            if (rbits > half || (rbits == half && (rm != 0 || mant[0]))) mant = mant + 1;
            if (mant == (64'd1 << (mw + 1))) begin
                mant = mant >> 1;
                e    = e + 1;
            end
            if (e >= int'(emax)) begin
                res = inf;
                fl  = 4'b0010;
            end else if (e <= 0) begin
                res = sgn << (ew + mw);
                fl  = 4'b0001;
            end else begin
                res = (sgn << (ew + mw)) | (64'(e) << mw) | (mant & fmask);
            end
        end
    endfunction

    function automatic logic [63:0] rand_operand(input int unsigned ew, input int unsigned mw);
        int unsigned emax, pick;
        logic [63:0] s, e, f;
        emax = (1 << ew) - 1;
        pick = $urandom_range(0, 11);
        s = 64'($urandom_range(0, 1));
        f = {$urandom, $urandom} & ((64'd1 << mw) - 64'd1);
        case (pick)
            0:       e = 64'd0;
            1:       e = 64'(emax);
            2:       begin e = 64'(emax); f = 64'd0; end
            3:       e = 64'(emax - 1 - $urandom_range(0, 2));
            4:       e = 64'(1 + $urandom_range(0, 2));
            5:       f = 64'd0;
            default: e = 64'($urandom_range(1, emax - 1));
        endcase
        if (pick == 5) e = 64'($urandom_range(1, emax - 1));
        return (s << (ew + mw)) | (e << mw) | f;
    endfunction

    task automatic mon_check(input int which, input logic busy_v, input logic done_v,
                             input logic [63:0] out_v, input logic [3:0] fl_v);
        exp_t e;
        bit   bexp;
        bit   empty;
        bexp = (cyc >= blo[which]) && (cyc <= bhi[which]);
        checks++;
        if (busy_v !== bexp) begin
            failures++;
            $display("FAIL busy%0d cyc=%0d got=%b want=%b", which, cyc, busy_v, bexp);
        end
        if (done_v === 1'b1) begin
            checks++;
            empty = (which == 0) ? (sb0.size() == 0) : (sb1.size() == 0);
            if (empty) begin
                failures++;
                $display("FAIL unexpected_done%0d cyc=%0d got out=%h want no done", which, cyc, out_v);
            end else begin
                if (which == 0) e = sb0.pop_front();
                else            e = sb1.pop_front();
                if (out_v !== e.res || fl_v !== e.fl || cyc != e.due) begin
                    failures++;
                    $display("FAIL result%0d cyc=%0d got out=%h flags=%b want out=%h flags=%b at cyc=%0d",
                             which, cyc, out_v, fl_v, e.res, e.fl, e.due);
                end
            end
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            mon_check(0, busy0, done0, 64'(out0), flags0);
            mon_check(1, busy1, done1, 64'(out1), flags1);
        end
    end

    task automatic clear_expect();
        sb0.delete();
        sb1.delete();
        blo = '{1, 1};
        bhi = '{0, 0};
    endtask

    task automatic issue(input int which, input logic [63:0] av, input logic [63:0] bv,
                         input logic [63:0] eres, input logic [3:0] efl, input int unsigned elat);
        exp_t e;
        e.res = eres;
        e.fl  = efl;
        e.due = cyc + 1 + elat;
        blo[which] = cyc + 2;
        bhi[which] = cyc + elat;
        if (which == 0) begin
            a0 = av[31:0]; b0 = bv[31:0]; start0 = 1'b1; sb0.push_back(e);
        end else begin
            a1 = av[15:0]; b1 = bv[15:0]; start1 = 1'b1; sb1.push_back(e);
        end
        @(posedge clk); #1;
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic wait_done(input int which);
        for (int i = 0; i < 200; i++) begin
            if (((which == 0) ? done0 : done1) === 1'b1) return;
            @(posedge clk); #1;
        end
        checks++;
        failures++;
        $display("FAIL timeout%0d cyc=%0d got no done want done within 200 cycles", which, cyc);
        @(negedge clk);
        rst_n = 1'b0;
        clear_expect();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic run_fixed(input int which, input logic [63:0] av, input logic [63:0] bv,
                             input logic [63:0] eres, input logic [3:0] efl, input int unsigned elat);
        issue(which, av, bv, eres, efl, elat);
        wait_done(which);
    endtask

    task automatic run_rand(input int which);
        int unsigned ew, mw, lat;
        logic [63:0] av, bv, res;
        logic [3:0]  fl;
        ew = (which == 0) ? 8 : 5;
        mw = (which == 0) ? 23 : 10;
        av = rand_operand(ew, mw);
        bv = rand_operand(ew, mw);
        ref_div(ew, mw, av, bv, res, fl, lat);
        run_fixed(which, av, bv, res, fl, lat);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy0, done0, out0, flags0, busy1, done1, out1, flags1} !== '0) begin
            failures++;
            $display("FAIL reset_state got busy=%b done=%b out=%h flags=%b want all zero",
                     busy0, done0, out0, flags0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_fixed(0, 64'h40C00000, 64'h40000000, 64'h40400000, 4'b0000, 29);
        run_fixed(0, 64'h3F800000, 64'h40400000, 64'h3EAAAAAB, 4'b0000, 29);
        run_fixed(0, 64'hBF800000, 64'h40400000, 64'hBEAAAAAB, 4'b0000, 29);
        run_fixed(0, 64'h3F800000, 64'h00000000, 64'h7F800000, 4'b0100, 2);
        run_fixed(0, 64'h00000000, 64'h00000000, 64'h7FC00000, 4'b1000, 2);
        run_fixed(0, 64'h7F800000, 64'h40000000, 64'h7F800000, 4'b0000, 2);
        run_fixed(0, 64'h7F000000, 64'h3E800000, 64'h7F800000, 4'b0010, 29);
        run_fixed(0, 64'h00800000, 64'h40800000, 64'h00000000, 4'b0001, 29);
        run_fixed(0, 64'hFFC12345, 64'h3F800000, 64'h7FC00000, 4'b1000, 2);
        run_fixed(0, 64'h7F800000, 64'hFF800000, 64'h7FC00000, 4'b1000, 2);
        run_fixed(0, 64'hC0000000, 64'h7F800000, 64'h80000000, 4'b0000, 2);
        run_fixed(0, 64'h40000000, 64'h80000000, 64'hFF800000, 4'b0100, 2);
        run_fixed(0, 64'h80000000, 64'h40000000, 64'h80000000, 4'b0000, 2);

        // start during busy is dropped; only the first operation completes
        issue(0, 64'h40C00000, 64'h40000000, 64'h40400000, 4'b0000, 29);
        repeat (4) @(posedge clk);
        #1;
        a0 = 32'h3F800000; b0 = 32'h40400000; start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        wait_done(0);
        repeat (35) @(posedge clk);
        #1;

        // reset mid-operation: outputs clear at once and the op never completes
        issue(0, 64'h3F800000, 64'h40400000, 64'h3EAAAAAB, 4'b0000, 29);
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        clear_expect();
        #1;
        checks++;
        if ({busy0, done0, out0, flags0} !== '0) begin
            failures++;
            $display("FAIL reset_mid_op got busy=%b done=%b out=%h flags=%b want all zero",
                     busy0, done0, out0, flags0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;

        for (int i = 0; i < 60; i++) run_rand(0);

        run_fixed(1, 64'h4600, 64'h4000, 64'h4200, 4'b0000, 16);
        run_fixed(1, 64'h3C00, 64'h0000, 64'h7C00, 4'b0100, 2);
        for (int i = 0; i < 30; i++) run_rand(1);

        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (sb0.size() != 0 || sb1.size() != 0) begin
            failures++;
            $display("FAIL drain got pending=%0d/%0d want 0/0", sb0.size(), sb1.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
